// File: rtl/block_morph_pool_pkg.sv
// Shared constants, mode and FSM encodings for the block morphology pooling stage.
// Pure declarations: no latency, no flow control.
package block_morph_pool_pkg;
    localparam int IMG_X    = 640;
    localparam int IMG_Y    = 480;
    localparam int P_W      = 12;
    localparam int BLK_MAX  = 16;
    localparam int CNT_W    = 9;
    localparam int COLS_MAX = 64;
    localparam int BX_W     = 6;
    localparam int BY_W     = 8;

    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;

    typedef enum logic {
        S_WAIT_SOF = 1'b0,
        S_RUN      = 1'b1
    } state_t;
endpackage

// File: rtl/block_morph_pool_if.sv
// Pixel-in / block-result-out bundle; o_white_blocks exists only with BLOCK_MORPH_STATS_EN.
// Strobe-only stream: no ready, the source is never stalled.
interface block_morph_pool_if;
    import block_morph_pool_pkg::*;

    logic            i_valid;
    logic            i_sof;
    logic            i_wb;
    logic            o_valid;
    logic            o_wb;
    logic [BX_W-1:0] o_bx;
    logic [BY_W-1:0] o_by;
    logic            o_frame_done;
`ifdef BLOCK_MORPH_STATS_EN
    logic [BX_W+BY_W-1:0] o_white_blocks;

    modport master (output i_valid, i_sof, i_wb,
                    input  o_valid, o_wb, o_bx, o_by, o_frame_done, o_white_blocks);
    modport slave  (input  i_valid, i_sof, i_wb,
                    output o_valid, o_wb, o_bx, o_by, o_frame_done, o_white_blocks);
`else
    modport master (output i_valid, i_sof, i_wb,
                    input  o_valid, o_wb, o_bx, o_by, o_frame_done);
    modport slave  (input  i_valid, i_sof, i_wb,
                    output o_valid, o_wb, o_bx, o_by, o_frame_done);
`endif
endinterface

// File: rtl/block_morph_acc.sv
// Per-column saturating pixel-count accumulators: combinational read-modify-write sum, clear-on-emit, global clear.
// Sum is combinational; update lands on the next edge; no backpressure.
module block_morph_acc
    import block_morph_pool_pkg::*;
#(
    parameter int N  = COLS_MAX,
    parameter int W  = CNT_W,
    parameter int IW = BX_W
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          clr_all,
    input  logic          upd,
    input  logic [IW-1:0] idx,
    input  logic          inc,
    input  logic          emit,
    output logic [W-1:0]  sum
);
    logic [W-1:0] acc [N];
    logic [W-1:0] base;
    logic [W:0]   raw;

    // A global clear on the same pixel means the column starts from zero.
    always_comb begin
        base = clr_all ? '0 : acc[idx];
        raw  = {1'b0, base} + {{W{1'b0}}, inc};
        sum  = raw[W] ? {W{1'b1}} : raw[W-1:0];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (upd && idx == IW'(i))
                    acc[i] <= emit ? '0 : sum;
                else if (clr_all)
                    acc[i] <= '0;
            end
        end
    end
endmodule

// File: rtl/block_morph_pool.sv
// Tiles a raster binary stream into BLKxBLK blocks and thresholds each block's polarity count (stats: BLOCK_MORPH_STATS_EN).
// 1-cycle latency from last block pixel to o_valid; no backpressure, every i_valid pixel is consumed.
module block_morph_pool #(
    parameter int IMG_X = block_morph_pool_pkg::IMG_X,
    parameter int IMG_Y = block_morph_pool_pkg::IMG_Y
) (
    input  logic                                   sys_clk,
    input  logic                                   sys_rst_n,
    block_morph_pool_if.slave                      pix,
    input  logic [4:0]                             i_blk_size,
    input  logic [block_morph_pool_pkg::P_W-1:0]   i_x1,
    input  logic [block_morph_pool_pkg::P_W-1:0]   i_x2,
    input  logic [block_morph_pool_pkg::P_W-1:0]   i_y1,
    input  logic [block_morph_pool_pkg::P_W-1:0]   i_y2,
    input  logic [block_morph_pool_pkg::CNT_W-1:0] i_thresh,
    input  logic                                   i_mode
);
    import block_morph_pool_pkg::*;

    localparam int BLK_W = 5;
    localparam logic [BLK_W-1:0] BLK_HI = BLK_W'(BLK_MAX);
    localparam logic [P_W-1:0]   X_LAST = P_W'(IMG_X - 1);
    localparam logic [P_W-1:0]   Y_LAST = P_W'(IMG_Y - 1);
    localparam logic [P_W-1:0]   COL_LIM = P_W'(COLS_MAX);

    state_t state, state_nxt;
    logic   accept, frame_start;

    logic [P_W-1:0]   cnt_x, cnt_y, px, py;
    logic [BLK_W-1:0] sh_blk, blk_in, blk, blk_m1;
    logic [P_W-1:0]   sh_x1, sh_x2, sh_y1, sh_y2, x1, x2, y1, y2;
    logic [CNT_W-1:0] sh_th, th, sum;
    logic             sh_mode, mode;

    logic [BLK_W-1:0] x0, y0, cx0, cy0, x0_nxt, y0_nxt;
    logic [P_W-1:0]   bx, cbx, bx_nxt;
    logic [BY_W-1:0]  by, cby, by_nxt;
    logic             in_win, col_ok, emit, hit, res_wb, done_nxt;

    logic             o_valid_q, o_wb_q, o_frame_done_q;
    logic [BX_W-1:0]  o_bx_q;
    logic [BY_W-1:0]  o_by_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_WAIT_SOF;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_SOF: if (pix.i_valid && pix.i_sof) state_nxt = S_RUN;
            default:    state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        frame_start = 1'b0;
        case (state)
            S_WAIT_SOF: begin
                accept      = pix.i_valid && pix.i_sof;
                frame_start = accept;
            end
            default: begin
                accept      = pix.i_valid;
                frame_start = pix.i_valid && (pix.i_sof || (cnt_x == '0 && cnt_y == '0));
            end
        endcase
    end

    // The frame's first pixel already uses the freshly presented config and zeroed block state.
    always_comb begin
        px     = pix.i_sof ? '0 : cnt_x;
        py     = pix.i_sof ? '0 : cnt_y;
        blk_in = (i_blk_size < 5'd2) ? 5'd2 : ((i_blk_size > BLK_HI) ? BLK_HI : i_blk_size);
        blk    = frame_start ? blk_in   : sh_blk;
        x1     = frame_start ? i_x1     : sh_x1;
        x2     = frame_start ? i_x2     : sh_x2;
        y1     = frame_start ? i_y1     : sh_y1;
        y2     = frame_start ? i_y2     : sh_y2;
        th     = frame_start ? i_thresh : sh_th;
        mode   = frame_start ? i_mode   : sh_mode;
        cx0    = frame_start ? '0 : x0;
        cy0    = frame_start ? '0 : y0;
        cbx    = frame_start ? '0 : bx;
        cby    = frame_start ? '0 : by;
        blk_m1 = blk - 1'b1;
        in_win = accept && px >= x1 && px <= x2 && py >= y1 && py <= y2;
        col_ok = cbx < COL_LIM;
        emit   = in_win && col_ok && cx0 == blk_m1 && cy0 == blk_m1;
        hit    = pix.i_wb == mode;
        res_wb = (mode == MODE_DILATE) ? (sum > th) : (sum <= th);
        done_nxt = accept && px == X_LAST && py == Y_LAST;

        x0_nxt = cx0;
        y0_nxt = cy0;
        bx_nxt = cbx;
        by_nxt = cby;
        if (in_win) begin
            if (px == x2) begin
                x0_nxt = '0;
                bx_nxt = '0;
                y0_nxt = (cy0 == blk_m1) ? '0 : cy0 + 1'b1;
                by_nxt = (cy0 == blk_m1) ? cby + 1'b1 : cby;
            end else begin
                x0_nxt = (cx0 == blk_m1) ? '0 : cx0 + 1'b1;
                bx_nxt = (cx0 == blk_m1) ? cbx + 1'b1 : cbx;
            end
        end
    end

    block_morph_acc u_acc (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr_all   (frame_start),
        .upd       (in_win && col_ok),
        .idx       (cbx[BX_W-1:0]),
        .inc       (hit),
        .emit      (emit),
        .sum       (sum)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_x <= '0;  cnt_y <= '0;
            x0 <= '0;  y0 <= '0;  bx <= '0;  by <= '0;
            sh_blk <= '0; sh_x1 <= '0; sh_x2 <= '0; sh_y1 <= '0; sh_y2 <= '0;
            sh_th <= '0;  sh_mode <= 1'b0;
            o_valid_q <= 1'b0; o_wb_q <= 1'b0; o_bx_q <= '0; o_by_q <= '0;
            o_frame_done_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_x <= (px == X_LAST) ? '0 : px + 1'b1;
                cnt_y <= (px != X_LAST) ? py : ((py == Y_LAST) ? '0 : py + 1'b1);
            end
            if (frame_start) begin
                sh_blk <= blk_in; sh_x1 <= i_x1; sh_x2 <= i_x2;
                sh_y1 <= i_y1;    sh_y2 <= i_y2; sh_th <= i_thresh; sh_mode <= i_mode;
            end
            x0 <= x0_nxt;  y0 <= y0_nxt;  bx <= bx_nxt;  by <= by_nxt;
            o_valid_q      <= emit;
            o_wb_q         <= emit && res_wb;
            o_bx_q         <= emit ? cbx[BX_W-1:0] : '0;
            o_by_q         <= emit ? cby : '0;
            o_frame_done_q <= done_nxt;
        end
    end

    assign pix.o_valid      = o_valid_q;
    assign pix.o_wb         = o_wb_q;
    assign pix.o_bx         = o_bx_q;
    assign pix.o_by         = o_by_q;
    assign pix.o_frame_done = o_frame_done_q;

`ifdef BLOCK_MORPH_STATS_EN
    logic [BX_W+BY_W-1:0] white_cnt, white_inc, white_q;

    assign white_inc = white_cnt + {{(BX_W+BY_W-1){1'b0}}, (emit && res_wb)};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            white_cnt <= '0;
            white_q   <= '0;
        end else if (frame_start) begin
            white_cnt <= '0;
        end else if (done_nxt) begin
            white_q   <= white_inc;
            white_cnt <= '0;
        end else begin
            white_cnt <= white_inc;
        end
    end

    assign pix.o_white_blocks = white_q;
`endif
endmodule

// File: tb/tb_block_morph_pool.sv
// Directed-vector bench for block_morph_pool on a reduced 20x18 raster.
module tb_block_morph_pool;
    import block_morph_pool_pkg::*;

    localparam int TX = 20;
    localparam int TY = 18;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [4:0]       blk_size;
    logic [P_W-1:0]   x1, x2, y1, y2;
    logic [CNT_W-1:0] thresh;
    logic             mode;

    block_morph_pool_if pix();

    block_morph_pool #(.IMG_X(TX), .IMG_Y(TY)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pix        (pix),
        .i_blk_size (blk_size),
        .i_x1       (x1),
        .i_x2       (x2),
        .i_y1       (y1),
        .i_y2       (y2),
        .i_thresh   (thresh),
        .i_mode     (mode)
    );

    always #5 sys_clk = ~sys_clk;

    int   total = 0;
    int   bad = 0;
    logic img [TY][TX];
    logic res [8][8];
    int   drv_x = 0, drv_y = 0, cap_x = 0, cap_y = 0;
    int   exp_blk = 4, exp_x1 = 0, exp_y1 = 0;
    int   n_blk = 0, n_done = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge sys_clk) begin
        cap_x <= drv_x;
        cap_y <= drv_y;
    end

    // Each result must arrive right after the block's bottom-right pixel.
    always @(negedge sys_clk) begin
        if (pix.o_valid) begin
            n_blk++;
            if (pix.o_bx < 8 && pix.o_by < 8) res[pix.o_by[2:0]][pix.o_bx[2:0]] = pix.o_wb;
            check("blk_x", cap_x, exp_x1 + exp_blk * int'(pix.o_bx) + exp_blk - 1);
            check("blk_y", cap_y, exp_y1 + exp_blk * int'(pix.o_by) + exp_blk - 1);
        end else begin
            check("idle_zero", int'({pix.o_wb, pix.o_bx, pix.o_by}), 0);
        end
        if (pix.o_frame_done) begin
            n_done++;
            check("done_x", cap_x, TX - 1);
            check("done_y", cap_y, TY - 1);
        end
    end

    task automatic fill(input logic v);
        for (int y = 0; y < TY; y++)
            for (int x = 0; x < TX; x++) img[y][x] = v;
    endtask

    task automatic paint(input int bx, input int by, input int n, input logic v);
        for (int k = 0; k < n; k++) img[by * 4 + k / 4][bx * 4 + k % 4] = v;
    endtask

    task automatic clear_res();
        n_blk = 0;
        n_done = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) res[i][j] = 1'b0;
    endtask

    function automatic int sum_res();
        int s = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) s += int'(res[i][j]);
        return s;
    endfunction

    task automatic cfg(input int b, input int xa, input int xb, input int ya, input int yb,
                       input int th, input logic m, input int eb);
        blk_size = 5'(b);
        x1 = P_W'(xa); x2 = P_W'(xb); y1 = P_W'(ya); y2 = P_W'(yb);
        thresh = CNT_W'(th);
        mode = m;
        exp_blk = eb; exp_x1 = xa; exp_y1 = ya;
    endtask

    task automatic idle(input int n);
        pix.i_valid = 1'b0;
        pix.i_sof = 1'b0;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic frame(input logic sof, input int rows, input int new_blk);
        for (int y = 0; y < rows; y++)
            for (int x = 0; x < TX; x++) begin
                if (new_blk != 0 && y == 5 && x == 0) blk_size = 5'(new_blk);
                pix.i_valid = 1'b1;
                pix.i_sof = sof && x == 0 && y == 0;
                pix.i_wb = img[y][x];
                drv_x = x;
                drv_y = y;
                @(posedge sys_clk);
                #1;
            end
        pix.i_valid = 1'b0;
        pix.i_sof = 1'b0;
    endtask

    task automatic check_white(input string tag, input int exp);
`ifdef BLOCK_MORPH_STATS_EN
        check(tag, int'(pix.o_white_blocks), exp);
`else
        if (exp < 0) $display("%s unused", tag);
`endif
    endtask

    initial begin
        pix.i_valid = 1'b0; pix.i_sof = 1'b0; pix.i_wb = 1'b0;
        cfg(4, 0, 15, 0, 15, 3, MODE_ERODE, 4);
        fill(1'b1);
        clear_res();
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_valid", int'(pix.o_valid), 0);
        check("rst_done", int'(pix.o_frame_done), 0);
        check_white("rst_white", 0);
        sys_rst_n = 1'b1;
        idle(2);

        // All-white erode frame: no black pixels, every block passes.
        clear_res();
        frame(1'b1, TY, 0); idle(3);
        check("t1_nblk", n_blk, 16);
        check("t1_done", n_done, 1);
        check("t1_sum", sum_res(), 16);
        check_white("t1_white", 16);

        // Four black pixels exceed thresh 3; three do not.
        fill(1'b1); paint(1, 0, 4, 1'b0); paint(2, 1, 3, 1'b0);
        clear_res();
        frame(1'b1, TY, 0); idle(3);
        check("t2_nblk", n_blk, 16);
        check("t2_b10", int'(res[0][1]), 0);
        check("t2_b21", int'(res[1][2]), 1);
        check("t2_sum", sum_res(), 15);
        check_white("t2_white", 15);

        // Dilate, thresh 8: nine whites pass, eight do not.
        fill(1'b0); paint(0, 0, 9, 1'b1); paint(3, 3, 8, 1'b1);
        cfg(4, 0, 15, 0, 15, 8, MODE_DILATE, 4);
        clear_res();
        frame(1'b1, TY, 0); idle(3);
        check("t3_nblk", n_blk, 16);
        check("t3_b00", int'(res[0][0]), 1);
        check("t3_b33", int'(res[3][3]), 0);
        check("t3_sum", sum_res(), 1);
        check_white("t3_white", 1);

        // Window 0..17: partial right and bottom blocks stay silent.
        fill(1'b1);
        cfg(4, 0, 17, 0, 17, 3, MODE_ERODE, 4);
        clear_res();
        frame(1'b1, TY, 0); idle(3);
        check("t4_nblk", n_blk, 16);
        check("t4_done", n_done, 1);
        check("t4_sum", sum_res(), 16);

        // Mid-frame block size change waits for the next frame.
        cfg(4, 0, 15, 0, 15, 3, MODE_ERODE, 4);
        clear_res();
        frame(1'b1, TY, 8); idle(3);
        check("t5a_nblk", n_blk, 16);
        exp_blk = 8;
        clear_res();
        frame(1'b0, TY, 0); idle(3);
        check("t5b_nblk", n_blk, 4);
        check("t5b_sum", sum_res(), 4);
        check("t5b_done", n_done, 1);
        cfg(1, 0, 3, 0, 3, 3, MODE_ERODE, 2);
        clear_res();
        frame(1'b0, TY, 0); idle(3);
        check("t5c_nblk", n_blk, 4);
        check("t5c_sum", sum_res(), 4);
        check_white("t5c_white", 4);

        // Abandon a frame with black rows in block (0,0), then restart on i_sof.
        fill(1'b1); paint(0, 0, 16, 1'b0);
        cfg(4, 0, 15, 0, 15, 3, MODE_ERODE, 4);
        clear_res();
        frame(1'b1, 3, 0);
        fill(1'b1);
        frame(1'b1, TY, 0); idle(3);
        check("t6_nblk", n_blk, 16);
        check("t6_done", n_done, 1);
        check("t6_b00", int'(res[0][0]), 1);
        check("t6_sum", sum_res(), 16);
        check_white("t6_white", 16);

        // Reset mid-frame, then non-sof pixels must be ignored until i_sof.
        fill(1'b0);
        frame(1'b1, 2, 0);
        sys_rst_n = 1'b0;
        #2;
        check("t7_rst_valid", int'(pix.o_valid), 0);
        check_white("t7_rst_white", 0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        idle(2);
        clear_res();
        frame(1'b0, TY, 0); idle(3);
        check("t7_ignored_blk", n_blk, 0);
        check("t7_ignored_done", n_done, 0);
        fill(1'b1);
        clear_res();
        frame(1'b1, TY, 0); idle(3);
        check("t7_nblk", n_blk, 16);
        check("t7_done", n_done, 1);
        check("t7_sum", sum_res(), 16);
        check_white("t7_white", 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
